// File: rtl/bbox_req_arbiter.sv
// Round-robin front end that shares one bbox intersection unit between N_CH requesters,
// tagging requests with the channel ID and steering responses back, bounded by a credit counter.
module bbox_req_arbiter #(
    parameter int N_CH    = 4,
    parameter int REQ_W   = 640,
    parameter int RESP_W  = 3,
    parameter int RID_W   = 8,
    parameter int MAX_OUT = 16,
    localparam int CH_W   = $clog2(N_CH),
    localparam int OUT_W  = $clog2(MAX_OUT + 1),
    localparam int UPQ_W  = REQ_W + RID_W,
    localparam int UPS_W  = RESP_W + RID_W,
    localparam int DNQ_W  = REQ_W + CH_W + RID_W,
    localparam int DNS_W  = RESP_W + CH_W + RID_W
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [N_CH*UPQ_W-1:0]   up_req_dat,
    input  logic [N_CH-1:0]         up_req_vld,
    output logic [N_CH-1:0]         up_req_rdy,
    output logic [N_CH*UPS_W-1:0]   up_resp_dat,
    output logic [N_CH-1:0]         up_resp_vld,
    input  logic [N_CH-1:0]         up_resp_rdy,
    output logic [DNQ_W-1:0]        bbox_req_stream_rsc_dat,
    output logic                    bbox_req_stream_rsc_vld,
    input  logic                    bbox_req_stream_rsc_rdy,
    input  logic [DNS_W-1:0]        bbox_resp_stream_rsc_dat,
    input  logic                    bbox_resp_stream_rsc_vld,
    output logic                    bbox_resp_stream_rsc_rdy,
    output logic [OUT_W-1:0]        outstanding,
    output logic                    err
);

    logic               reqValid_q, reqValid_d;
    logic [DNQ_W-1:0]   reqData_q, reqData_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [OUT_W-1:0]   outCnt_q, outCnt_d;
    logic               err_q, err_d;
    logic [N_CH-1:0]    respValid_q, respValid_d;
    logic [UPS_W-1:0]   respData_q [N_CH];
    logic [UPS_W-1:0]   respData_d [N_CH];

    logic               regFree;
    logic               creditOk;
    logic               grantFound;
    logic               grantFire;
    logic [CH_W-1:0]    grantCh;
    logic [CH_W:0]      probeSum;
    logic [CH_W-1:0]    probe;
    logic [UPQ_W-1:0]   grantSlice;

    logic [CH_W-1:0]    respCh;
    logic [RID_W-1:0]   respRid;
    logic [RESP_W-1:0]  respPay;
    logic               respLegal;
    logic               respAccept;
    logic               creditDec;

    // Search upward from the pointer, wrapping, for the first requesting channel.
    always_comb begin
        grantFound = 1'b0;
        grantCh    = '0;
        probeSum   = '0;
        probe      = '0;
        for (int k = 0; k < N_CH; k++) begin
            probeSum = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (probeSum >= (CH_W+1)'(N_CH)) begin
                probeSum = probeSum - (CH_W+1)'(N_CH);
            end
            probe = probeSum[CH_W-1:0];
            if (!grantFound && up_req_vld[probe]) begin
                grantFound = 1'b1;
                grantCh    = probe;
            end
        end
    end

    assign regFree    = !reqValid_q || bbox_req_stream_rsc_rdy;
    assign creditOk   = outCnt_q < OUT_W'(MAX_OUT);
    assign grantFire  = !arst && regFree && creditOk && grantFound;
    assign up_req_rdy = grantFire ? (N_CH'(1) << grantCh) : '0;
    assign grantSlice = up_req_dat[int'(grantCh)*UPQ_W +: UPQ_W];

    always_comb begin
        reqValid_d = reqValid_q;
        reqData_d  = reqData_q;
        ptr_d      = ptr_q;
        if (reqValid_q && bbox_req_stream_rsc_rdy) begin
            reqValid_d = 1'b0;
        end
        if (grantFire) begin
            reqValid_d = 1'b1;
            reqData_d  = {grantSlice[UPQ_W-1:RID_W], grantCh, grantSlice[RID_W-1:0]};
            ptr_d      = (int'(grantCh) == N_CH - 1) ? '0 : grantCh + 1'b1;
        end
    end

    assign respRid    = bbox_resp_stream_rsc_dat[RID_W-1:0];
    assign respCh     = bbox_resp_stream_rsc_dat[RID_W +: CH_W];
    assign respPay    = bbox_resp_stream_rsc_dat[DNS_W-1 -: RESP_W];
    assign respLegal  = {1'b0, respCh} < (CH_W+1)'(N_CH);

    // Out-of-range channel IDs are always accepted so they cannot wedge the bbox stream.
    always_comb begin
        bbox_resp_stream_rsc_rdy = 1'b1;
        if (respLegal) begin
            bbox_resp_stream_rsc_rdy = !respValid_q[respCh] || up_resp_rdy[respCh];
        end
    end

    assign respAccept = bbox_resp_stream_rsc_vld && bbox_resp_stream_rsc_rdy;

    always_comb begin
        respValid_d = respValid_q & ~up_resp_rdy;
        respData_d  = respData_q;
        if (respAccept && respLegal) begin
            respValid_d[respCh] = 1'b1;
            respData_d[respCh]  = {respPay, respRid};
        end
    end

    // Credits are taken at grant time; a response with no credit left never underflows.
    always_comb begin
        outCnt_d  = outCnt_q;
        err_d     = err_q;
        creditDec = respAccept && (outCnt_q != '0);
        if (grantFire && !creditDec) begin
            outCnt_d = outCnt_q + 1'b1;
        end else if (!grantFire && creditDec) begin
            outCnt_d = outCnt_q - 1'b1;
        end
        if (respAccept && (!respLegal || outCnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            reqValid_q  <= 1'b0;
            reqData_q   <= '0;
            ptr_q       <= '0;
            outCnt_q    <= '0;
            err_q       <= 1'b0;
            respValid_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                respData_q[i] <= '0;
            end
        end else begin
            reqValid_q  <= reqValid_d;
            reqData_q   <= reqData_d;
            ptr_q       <= ptr_d;
            outCnt_q    <= outCnt_d;
            err_q       <= err_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
        end
    end

    assign bbox_req_stream_rsc_dat = reqData_q;
    assign bbox_req_stream_rsc_vld = reqValid_q;
    assign up_resp_vld             = respValid_q;
    assign outstanding             = outCnt_q;
    assign err                     = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_resp
            assign up_resp_dat[gi*UPS_W +: UPS_W] = respData_q[gi];
        end
    endgenerate

endmodule
